// File: rtl/hpf_pkg.sv
// hpf_pkg: shared state encoding and fixed operand widths for the HPF MAC sequencer
package hpf_pkg;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    localparam int DW = 9;
    localparam int PW = 18;
endpackage

// File: rtl/hpf_delay_line.sv
// hpf_delay_line: TAPS-deep sample shift register with a registered-index tap mux
module hpf_delay_line
    import hpf_pkg::*;
#(
    parameter int TAPS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic [DW-1:0]           din,
    input  logic [$clog2(TAPS)-1:0] tap_sel,
    output logic [DW-1:0]           tap_out
);
    logic [DW-1:0] d_q [TAPS];
    logic [DW-1:0] d_d [TAPS];

    // Newest sample enters at tap 0; the oldest falls off the end
    always_comb begin
        d_d = d_q;
        if (shift_en) begin
            d_d[0] = din;
            for (int i = 1; i < TAPS; i++) d_d[i] = d_q[i-1];
        end
    end

    // Delay line storage, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) d_q[i] <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign tap_out = d_q[tap_sel];
endmodule

// File: rtl/hpf_mac_sequencer.sv
// hpf_mac_sequencer: time-multiplexed FIR tap controller feeding one external 9x9 multiplier.
// Optional HPF_MUL_PIPE_EN registers mul_p locally and adds one drain cycle per sample.
module hpf_mac_sequencer
    import hpf_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int ACCW = PW + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_sample,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [DW-1:0]           coef_data,
    output logic [DW-1:0]           mul_x,
    output logic [DW-1:0]           mul_y,
    input  logic [PW-1:0]           mul_p,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACCW-1:0]         out_data,
    output logic                    busy
);
    localparam int AW = $clog2(TAPS);
    localparam int IW = AW + 1;
`ifdef HPF_MUL_PIPE_EN
    localparam int LAST = TAPS;
`else
    localparam int LAST = TAPS - 1;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0] coef_q [TAPS];
    logic [DW-1:0] coef_d [TAPS];
    logic [DW-1:0] tap_out;
    logic [PW-1:0] prod;
    logic          mac_on;

    assign mac_on    = (state_q == MAC) && (idx_q < IW'(TAPS));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? acc_q : '0;
    assign busy      = (state_q != IDLE);
    assign mul_x     = mac_on ? tap_out : '0;
    assign mul_y     = mac_on ? coef_q[idx_q[AW-1:0]] : '0;

    hpf_delay_line #(.TAPS(TAPS)) u_dl (
        .clk      (clk),
        .rst      (rst),
        .shift_en (in_valid && in_ready),
        .din      (in_sample),
        .tap_sel  (idx_q[AW-1:0]),
        .tap_out  (tap_out)
    );

`ifdef HPF_MUL_PIPE_EN
    logic [PW-1:0] prod_q, prod_d;
    assign prod_d = mul_p;
    assign prod   = (idx_q != '0) ? prod_q : '0;

    // Product pipeline register; the first MAC cycle has no valid product yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prod_q <= '0;
        else     prod_q <= prod_d;
    end
`else
    assign prod = mul_p;
`endif

    // Next-state, accumulate and coefficient-write logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        coef_d  = coef_q;
        if (state_q == IDLE && coef_we) coef_d[coef_addr] = coef_data;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = MAC;
                idx_d   = '0;
                acc_d   = '0;
            end
            MAC: begin
                acc_d = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(LAST)) state_d = OUT;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, index, accumulator and coefficient registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            coef_q  <= coef_d;
        end
    end
endmodule

// File: tb/tb_hpf_mac_sequencer.sv
// tb_hpf_mac_sequencer: directed scoreboard bench with an exact behavioural multiplier
module tb_hpf_mac_sequencer;
    localparam int TAPS = 8;
`ifdef HPF_MUL_PIPE_EN
    localparam int LAT = 10;
    localparam int PER = 11;
`else
    localparam int LAT = 9;
    localparam int PER = 10;
`endif

    logic clk = 0, rst = 1, in_valid = 0, coef_we = 0, out_ready = 1;
    logic in_ready, out_valid, busy;
    logic signed [8:0]  in_sample = 0, coef_data = 0, mul_x, mul_y;
    logic [2:0]         coef_addr = 0;
    logic signed [17:0] mul_p;
    logic signed [20:0] out_data;

    int checks = 0, failures = 0, cyc = 0;
    int dm [TAPS];
    int cm [TAPS];
    int exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mul_p = mul_x * mul_y;

    hpf_mac_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int golden();
        int s = 0;
        for (int i = 0; i < TAPS; i++) s += dm[i] * cm[i];
        return s;
    endfunction

    task automatic wcoef(input int a, input int v);
        coef_we = 1; coef_addr = a[2:0]; coef_data = v[8:0]; cm[a] = v;
        @(negedge clk);
        coef_we = 0;
    endtask

    task automatic send(input int s);
        int n = 0;
        in_valid = 1; in_sample = s[8:0];
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        else begin
            for (int i = TAPS-1; i > 0; i--) dm[i] = dm[i-1];
            dm[0] = s;
            exp_q.push_back(golden());
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic recv(input string tag, output logic signed [31:0] got);
        int n = 0;
        while (!out_valid && n < 60) begin @(negedge clk); n++; end
        got = out_data;
        chk({tag, "_valid"}, out_valid, 1);
        if (exp_q.size() == 0) chk({tag, "_queue"}, 0, 1);
        else chk(tag, got, exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        logic signed [31:0] got;
        int acc_t [3];
        int out_t, na, n, v;
        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_y", mul_y, 0);
        rst = 0;
        @(negedge clk);
        // impulse response
        for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
        send(1);
        recv("imp0", got);
        chk("imp0_const", got, 1);
        for (int k = 1; k <= TAPS; k++) begin
            send(0);
            recv("imp", got);
            chk("imp_const", got, (k < TAPS) ? k + 1 : 0);
        end
        // extremes
        for (int i = 0; i < TAPS; i++) wcoef(i, -256);
        for (int k = 0; k < TAPS; k++) begin send(-256); recv("ext", got); end
        chk("ext_final", got, 524288);
        // backpressure
        for (int i = 0; i < TAPS; i++) wcoef(i, i - 3);
        out_ready = 0;
        send(5);
        n = 0;
        while (!out_valid && n < 60) begin @(negedge clk); n++; end
        in_valid = 1; in_sample = 77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp_q[0]);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        recv("bp_out", got);
        in_sample = -100;
        @(negedge clk);
        chk("idle_mul_x", mul_x, 0);
        chk("idle_mul_y", mul_y, 0);
        send(-7);
        recv("bp_next", got);
        // coefficient write while busy is ignored
        send(9);
        coef_we = 1; coef_addr = 0; coef_data = 0;
        for (int i = 0; i < 3; i++) begin chk("cw_busy", busy, 1); @(negedge clk); end
        coef_we = 0;
        recv("cw_out", got);
        send(11);
        recv("cw_after", got);
        // reset during MAC
        send(7);
        @(negedge clk); @(negedge clk);
        rst = 1;
        #1;
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        exp_q.delete();
        for (int i = 0; i < TAPS; i++) begin dm[i] = 0; cm[i] = 0; end
        @(negedge clk);
        for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
        send(1);
        recv("mr_imp0", got);
        for (int k = 1; k < TAPS; k++) begin send(0); recv("mr_imp", got); end
        chk("mr_imp_last", got, TAPS);
        // streaming timing with in_valid held high
        out_t = -1; na = 0; n = 0;
        in_valid = 1;
        while (na < 3 && n < 200) begin
            v = 3 + na;
            in_sample = v[8:0];
            if (out_valid) begin
                if (out_t < 0) out_t = cyc;
                if (exp_q.size() == 0) chk("stream_queue", 0, 1);
                else chk("stream_data", out_data, exp_q.pop_front());
            end
            if (in_ready) begin
                acc_t[na] = cyc;
                na++;
                for (int i = TAPS-1; i > 0; i--) dm[i] = dm[i-1];
                dm[0] = v;
                exp_q.push_back(golden());
            end
            @(negedge clk);
            n++;
        end
        in_valid = 0;
        chk("stream_accepts", na, 3);
        chk("period_a", acc_t[1] - acc_t[0], PER);
        chk("period_b", acc_t[2] - acc_t[1], PER);
        chk("latency", out_t - acc_t[0], LAT);
        recv("stream_last", got);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
